actel_cfg_loader: RTL
=====================

ACTEL_CFG_LOADER -- requirements
Module: actel_cfg_loader

Interface
REQ-001 The module SHALL have parameter NUM_CELLS, default 8, giving the number of logic-cell configuration nibbles loaded; legal values are even, 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin a load session; one-cycle pulse.
REQ-005 cfg_valid  input  1  upstream byte valid.
REQ-006 cfg_data  input  8  configuration byte.
REQ-007 cfg_ready  output  1  loader accepts a byte this cycle.
REQ-008 cfg_out  output  4*NUM_CELLS  committed D[3:0] values; bits [4i+3:4i] drive cell i.
REQ-009 busy  output  1  session in progress.
REQ-010 done  output  1  last session committed successfully.
REQ-011 error  output  1  last session rejected.

Function
REQ-012 A byte SHALL transfer only on a rising edge where cfg_valid and cfg_ready are both 1; cfg_data is ignored otherwise.
REQ-013 The FSM SHALL have states IDLE, HDR, CNT, PAYLOAD, CHK, DONE, ERR.
REQ-014 IDLE/DONE/ERR: start=1 -> HDR next cycle, clearing done, error, byte index and running XOR; start is ignored in all other states.
REQ-015 HDR: the accepted byte SHALL equal 8'hA5 -> CNT; any other value -> ERR.
REQ-016 CNT: the accepted byte SHALL equal NUM_CELLS -> PAYLOAD; any other value -> ERR.
REQ-017 PAYLOAD: exactly NUM_CELLS/2 bytes accepted; byte k low nibble -> shadow cell 2k, high nibble -> shadow cell 2k+1; running XOR updated with each byte; after byte NUM_CELLS/2-1 -> CHK.
REQ-018 CHK: accepted byte equal to running XOR of payload bytes -> DONE; otherwise -> ERR.
REQ-019 cfg_out SHALL update only on entry to DONE, atomically from the shadow register, in the same edge that accepts the checksum byte; on ERR cfg_out SHALL retain its previous value.
REQ-020 cfg_ready SHALL be 1 exactly in HDR, CNT, PAYLOAD, CHK (Moore, no combinational path from cfg_valid).
REQ-021 busy SHALL be 1 exactly in HDR, CNT, PAYLOAD, CHK.
REQ-022 done SHALL be 1 exactly in DONE; error exactly in ERR; both hold until the next start or reset.
REQ-023 cfg_valid=0 in any accepting state SHALL stall the FSM indefinitely with no state or index change.
REQ-024 Byte index SHALL be ceil(log2(NUM_CELLS/2+1)) bits wide and SHALL never wrap within a session.
REQ-025 Minimum session latency: start to done SHALL be NUM_CELLS/2+4 cycles with cfg_valid held 1 (1 cycle start->HDR, then one byte per cycle).

Reset
REQ-026 clr=1 SHALL immediately force state IDLE, cfg_out=0, shadow=0, byte index=0, running XOR=0, done=0, error=0, busy=0, cfg_ready=0, regardless of clk.
REQ-027 clr asserted mid-session SHALL discard the partial session; cfg_out reads 0 after reset, not the previously committed value.

Verification
REQ-028 NUM_CELLS=4, start, stream A5,04,21,43,62 with cfg_valid=1 -> done=1 after 6 cycles from start, cfg_out=16'h4321, error=0.
REQ-029 After REQ-028, start, stream A5,04,21,43,00 -> error=1, done=0, cfg_out stays 16'h4321.
REQ-030 start, stream 5A -> ERR on next edge, cfg_ready=0 thereafter, further cfg_valid bytes ignored; start, stream A5,03 -> ERR.
REQ-031 Stream of REQ-028 with cfg_valid deasserted for 3 cycles between 21 and 43 -> same result as REQ-028, done delayed by 3 cycles; start pulsed during PAYLOAD -> no effect.
REQ-032 clr pulsed asynchronously (between edges) during PAYLOAD after done state of REQ-028 -> all outputs 0 immediately, cfg_out=0; new full session then loads correctly.

Source files
------------

// File: rtl/actel_cfg_loader.sv
// Serial configuration loader: header, cell count, packed nibble payload and an
// XOR checksum. The shadow image is committed to cfg_out only on a good checksum.
module actel_cfg_loader #(
  parameter int NUM_CELLS = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic                   cfg_valid,
  input  logic [7:0]             cfg_data,
  output logic                   cfg_ready,
  output logic [4*NUM_CELLS-1:0] cfg_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int NB    = NUM_CELLS / 2;
  localparam int IDX_W = $clog2(NB + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, CNT, PAYLOAD, CHK, DONE, ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [7:0]             xor_q, xor_d;
  logic [4*NUM_CELLS-1:0] shadow_q, shadow_d;
  logic [4*NUM_CELLS-1:0] cfg_out_q, cfg_out_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic                   accept;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    shadow_d  = shadow_q;
    cfg_out_d = cfg_out_q;
    accept    = cfg_valid && ready_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = HDR;
          idx_d   = '0;
          xor_d   = '0;
        end
      end
      HDR: begin
        if (accept) state_d = (cfg_data == 8'hA5) ? CNT : ERR;
      end
      CNT: begin
        if (accept) state_d = (cfg_data == 8'(NUM_CELLS)) ? PAYLOAD : ERR;
      end
      PAYLOAD: begin
        if (accept) begin
          // Byte k carries cell 2k in its low nibble and cell 2k+1 in its high nibble.
          for (int k = 0; k < NB; k++) begin
            if (idx_q == IDX_W'(k)) shadow_d[8*k +: 8] = cfg_data;
          end
          xor_d = xor_q ^ cfg_data;
          if (idx_q == LAST_IDX) state_d = CHK;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      CHK: begin
        if (accept) begin
          if (cfg_data == xor_q) begin
            state_d   = DONE;
            cfg_out_d = shadow_q;
          end else begin
            state_d   = ERR;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered with it.
    ready_d = (state_d == HDR) || (state_d == CNT) || (state_d == PAYLOAD) || (state_d == CHK);
    busy_d  = ready_d;
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      xor_q     <= '0;
      shadow_q  <= '0;
      cfg_out_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      shadow_q  <= shadow_d;
      cfg_out_q <= cfg_out_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cfg_out   = cfg_out_q;

endmodule
